hp_div: RTL
===========

HP_DIV -- requirements
Module: hp_div

Interface
REQ-001 SHALL have ports clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have ports rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have ports start, input, 1, request a new division; sampled only in IDLE.
REQ-004 SHALL have ports a, input, 16, dividend, IEEE 754 binary16.
REQ-005 SHALL have ports b, input, 16, divisor, IEEE 754 binary16.
REQ-006 SHALL have ports q, output, 16, quotient, registered.
REQ-007 SHALL have ports snan, qnan, infinity, zero, subnormal, normal, output, 1 each, class of q; one-hot whenever done has been seen.
REQ-008 SHALL have ports busy, output, 1, operation in progress.
REQ-009 SHALL have ports done, output, 1, one-cycle pulse; q and flags valid from this cycle.

Function
REQ-010 SHALL use FSM states IDLE, PREP, DIV, PACK.
- IDLE->PREP on start; a and b latched at that edge.
- PREP->IDLE for special cases; otherwise PREP->DIV.
- DIV->PACK after 12 iterations.
- PACK->IDLE.
REQ-011 SHALL treat start as ignored while busy=1; start in the cycle done=1 SHALL be accepted.
REQ-012 SHALL hold busy=1 from the edge accepting start until the edge raising done; busy=0 while done=1.
REQ-013 SHALL, for start sampled at edge k, raise done after edge k+2 for special cases and after edge k+15 for arithmetic results.
REQ-014 SHALL hold q and flags from done until the next done.
REQ-015 SHALL decide special cases in PREP, in this priority:
- a or b sNaN -> that operand (a first), snan.
- a or b qNaN -> that operand (a first), qnan.
- inf/inf or 0/0 -> {sign,11111,1,9'h2A}, qnan.
- inf/finite or finite nonzero/0 -> signed infinity.
- 0/nonzero or finite/inf -> signed zero.
REQ-016 SHALL compute sign as a[15]^b[15] for all non-propagated results.
REQ-017 SHALL, in PREP, normalise subnormal significands combinationally: shift left until bit10=1, decrementing unbiased exponent per shift.
REQ-018 SHALL, in DIV, perform restoring radix-2 division of 11-bit significands producing a 12-bit quotient, one bit per cycle, remainder discarded.
REQ-019 SHALL, in PACK:
- Unbiased exponent e=expA-expB in signed 7 bits.
- If quot[11]=1: sig=quot[11:1].
- Else: sig=quot[10:0], e=e-1.
REQ-020 SHALL range-map e in PACK:
- e<-24 -> signed zero.
- -24<=e<-14 -> subnormal, sig>>(-14-e), low 10 bits stored.
- e>15 -> signed infinity.
- Else normal with biased exponent e+15.
REQ-021 SHALL round toward zero (truncate) everywhere.

Reset
REQ-022 SHALL, while rst=1, force state IDLE, q=0, all flags 0, busy=0, done=0, independent of clk.
REQ-023 SHALL discard an in-flight operation on reset, with no done afterwards until a new start.

Structure
REQ-024 SHALL take BIAS=15, EMIN=-14, EMAX=15, QNAN_PAYLOAD=9'h2A, iteration count 12 and the FSM state enumeration from shared package hp_pkg.
REQ-025 SHALL instantiate hp_class twice for operand classification and exponent/significand extraction; no other sub-module.

Verification
REQ-026 SHALL cover a=0x3C00, b=0x4200 -> q=0x3555, normal, done after edge k+15.
REQ-027 SHALL cover a=0xBC00, b=0x0000 -> q=0xFC00, infinity, done after edge k+2; and a=0x0000, b=0x0000 -> q=0x7E2A, qnan.
REQ-028 SHALL cover a=0x7D00, b=0x3C00 -> q=0x7D00, snan; and a=0x3C00, b=0x7E00 -> q=0x7E00, qnan.
REQ-029 SHALL cover a=0x0400, b=0x4000 -> q=0x0200, subnormal; and a=0x7BFF, b=0x3800 -> q=0x7C00, infinity.
REQ-030 SHALL cover start during busy -> ignored.
REQ-031 SHALL cover rst pulsed in DIV -> outputs 0 and no done; next start 0x4000/0x4000 -> 0x3C00, normal.

Source files
------------

// File: rtl/hp_pkg.sv
// hp_pkg: shared constants, FSM states and result-class encoding for the binary16 divider.
package hp_pkg;
  localparam int BIAS = 15;
  localparam int EMIN = -14;
  localparam int EMAX = 15;
  localparam logic [8:0] QNAN_PAYLOAD = 9'h2A;
  localparam int ITERS = 12;
  typedef enum logic [1:0] {IDLE, PREP, DIV, PACK} state_t;
  typedef logic [5:0] cls_t;
  localparam cls_t CLS_SNAN = 6'b100000;
  localparam cls_t CLS_QNAN = 6'b010000;
  localparam cls_t CLS_INF  = 6'b001000;
  localparam cls_t CLS_ZERO = 6'b000100;
  localparam cls_t CLS_SUB  = 6'b000010;
  localparam cls_t CLS_NORM = 6'b000001;
endpackage

// File: rtl/hp_class.sv
// hp_class: classifies a binary16 operand and yields its normalised significand and unbiased exponent.
module hp_class
  import hp_pkg::*;
(
  input  logic [15:0]       i_x,
  output logic              o_snan,
  output logic              o_qnan,
  output logic              o_inf,
  output logic              o_zero,
  output logic signed [6:0] o_exp,
  output logic [10:0]       o_sig
);
  logic [4:0] w_e;
  logic [9:0] w_m;
  logic [3:0] w_lz;
  assign w_e = i_x[14:10];
  assign w_m = i_x[9:0];
  always_comb begin
    w_lz = 4'd0;
    for (int i = 0; i < 10; i++) if (w_m[i]) w_lz = 4'(10 - i);
  end
  assign o_snan = (&w_e) && (w_m != 10'd0) && !w_m[9];
  assign o_qnan = (&w_e) && w_m[9];
  assign o_inf  = (&w_e) && (w_m == 10'd0);
  assign o_zero = (w_e == 5'd0) && (w_m == 10'd0);
  // Subnormals are shifted up to a hidden-one form, losing one exponent step per shift.
  assign o_sig = (w_e == 5'd0) ? ({1'b0, w_m} << w_lz) : {1'b1, w_m};
  assign o_exp = (w_e == 5'd0) ? 7'(EMIN) - 7'(w_lz) : 7'(w_e) - 7'(BIAS);
endmodule

// File: rtl/hp_div.sv
// hp_div: binary16 divider, special cases in PREP, 12-step restoring division, truncating pack.
module hp_div
  import hp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] q,
  output logic        snan,
  output logic        qnan,
  output logic        infinity,
  output logic        zero,
  output logic        subnormal,
  output logic        normal,
  output logic        busy,
  output logic        done
);
  state_t r_state, w_next;
  logic [15:0] r_a, r_b, r_q, r_res, w_sres, w_pres;
  logic [11:0] r_rem, r_quot;
  logic [10:0] r_sigb, w_siga, w_sigb, w_diff, w_sig;
  logic signed [6:0] r_e, w_ea, w_eb, w_e1;
  logic [3:0] r_cnt, w_sh;
  logic [9:0] w_sub;
  cls_t r_cls, r_flags, w_scls, w_pcls;
  logic r_fin, r_busy, r_done, w_accept, w_spec, w_sign, w_ge;
  logic w_a_snan, w_a_qnan, w_a_inf, w_a_zero, w_b_snan, w_b_qnan, w_b_inf, w_b_zero;
  hp_class u_cls_a (.i_x(r_a), .o_snan(w_a_snan), .o_qnan(w_a_qnan), .o_inf(w_a_inf),
                    .o_zero(w_a_zero), .o_exp(w_ea), .o_sig(w_siga));
  hp_class u_cls_b (.i_x(r_b), .o_snan(w_b_snan), .o_qnan(w_b_qnan), .o_inf(w_b_inf),
                    .o_zero(w_b_zero), .o_exp(w_eb), .o_sig(w_sigb));
  assign w_accept = (r_state == IDLE) && start && !r_busy;
  assign w_sign = r_a[15] ^ r_b[15];
  always_comb begin
    w_spec = 1'b1;
    w_sres = 16'h0000;
    w_scls = CLS_ZERO;
    if (w_a_snan) begin w_sres = r_a; w_scls = CLS_SNAN; end
    else if (w_b_snan) begin w_sres = r_b; w_scls = CLS_SNAN; end
    else if (w_a_qnan) begin w_sres = r_a; w_scls = CLS_QNAN; end
    else if (w_b_qnan) begin w_sres = r_b; w_scls = CLS_QNAN; end
    else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
      w_sres = {w_sign, 5'h1F, 1'b1, QNAN_PAYLOAD}; w_scls = CLS_QNAN;
    end
    else if (w_a_inf || w_b_zero) begin w_sres = {w_sign, 5'h1F, 10'h000}; w_scls = CLS_INF; end
    else if (w_a_zero || w_b_inf) w_sres = {w_sign, 15'h0000};
    else w_spec = 1'b0;
  end
  assign w_ge = r_rem >= {1'b0, r_sigb};
  assign w_diff = 11'(w_ge ? r_rem - {1'b0, r_sigb} : r_rem);
  assign w_e1 = r_quot[11] ? r_e : r_e - 7'sd1;
  assign w_sig = r_quot[11] ? r_quot[11:1] : r_quot[10:0];
  assign w_sh = 4'(EMIN - int'(w_e1));
  assign w_sub = 10'(w_sig >> w_sh);
  always_comb begin
    w_pres = {w_sign, 5'(w_e1 + 7'(BIAS)), w_sig[9:0]};
    w_pcls = CLS_NORM;
    if (int'(w_e1) < EMIN - 10) begin w_pres = {w_sign, 15'h0000}; w_pcls = CLS_ZERO; end
    else if (int'(w_e1) < EMIN) begin w_pres = {w_sign, 5'd0, w_sub}; w_pcls = CLS_SUB; end
    else if (int'(w_e1) > EMAX) begin w_pres = {w_sign, 5'h1F, 10'h000}; w_pcls = CLS_INF; end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? PREP : IDLE;
      PREP:    w_next = w_spec ? IDLE : DIV;
      DIV:     w_next = (r_cnt == 4'(ITERS - 1)) ? PACK : DIV;
      PACK:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // Results are staged one edge before publication so q only changes together with done.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {r_a, r_b, r_q, r_res, r_rem, r_quot, r_sigb, r_e, r_cnt} <= '0;
      {r_cls, r_flags, r_fin, r_busy, r_done} <= '0;
    end else begin
      r_done <= r_fin;
      r_fin <= ((r_state == PREP) && w_spec) || (r_state == PACK);
      if (r_fin) begin r_q <= r_res; r_flags <= r_cls; r_busy <= 1'b0; end
      if (w_accept) begin r_a <= a; r_b <= b; r_busy <= 1'b1; end
      if (r_state == PREP) begin
        r_rem <= {1'b0, w_siga};
        r_quot <= '0;
        r_cnt <= '0;
        r_sigb <= w_sigb;
        r_e <= w_ea - w_eb;
        r_res <= w_sres;
        r_cls <= w_scls;
      end
      if (r_state == DIV) begin
        r_rem <= {w_diff, 1'b0};
        r_quot <= {r_quot[10:0], w_ge};
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == PACK) begin r_res <= w_pres; r_cls <= w_pcls; end
    end
  assign q = r_q;
  assign {snan, qnan, infinity, zero, subnormal, normal} = r_flags;
  assign busy = r_busy;
  assign done = r_done;
endmodule
